param_mealy_seq_detector: RTL and testbench
===========================================

# param_mealy_seq_detector

Parametrised Mealy sequence detector: the next generation of the team's fixed-pattern serial detectors such as the 10010 Mealy detector. It watches a 1-bit serial stream sampled on `clk`, flags a match combinationally in the cycle the final pattern bit is present, and keeps a saturating match count. Pattern length, reset pattern and counter width are generics. Pattern and overlap mode are run-time controls, so one instance replaces the per-pattern detectors in the lab datapath.

## Interface
- `N`, default 5: pattern length in bits, minimum 2.
- `PATTERN`, default 5'b10010: pattern loaded at reset. MSB is the first bit received.
- `CNT_W`, default 8: match counter width.

Ports:
- `clk`  in  1: single clock. All state updates on the rising edge.
- `rst`  in  1: reset, synchronous and active-low. The block is in reset when `rst`=0 at a rising edge of `clk`.
- `j`  in  1: serial data bit, sampled at the rising edge.
- `en`  in  1: sample enable. When 0, `j` is ignored.
- `overlap`  in  1: 1 = overlapping matches allowed; 0 = non-overlapping.
- `pat_load`  in  1: load `pat_in` into the pattern register.
- `pat_in`  in  N: new pattern, MSB first.
- `cnt_clr`  in  1: clear the match counter.
- `w`  out  1: Mealy match flag (combinational).
- `match_cnt`  out  CNT_W: saturating count of accepted matches.

## Operation
- State:
  - `hist[N-2:0]`: previous bits, newest in the LSB.
  - `fill`: number of valid history bits, 0..N-1.
  - `pat_r[N-1:0]`: current pattern.
  - `cnt[CNT_W-1:0]`: match counter.
- Match condition: `w` = `rst` & `en` & ~`pat_load` & (`fill`==N-1) & ({`hist`,`j`} == `pat_r`). It is purely combinational from the current inputs and state.
- Sample edge (`en`=1, `pat_load`=0):
  - `hist` <= {`hist[N-3:0]`, `j`}.
  - `fill` <= min(`fill`+1, N-1).
- Match edge (`w`=1):
  - `cnt` increments, saturating at 2^CNT_W-1.
  - If `overlap`=0, `fill` <= 0 so that bit does not start a new window. `hist` still shifts.
  - If `overlap`=1, `fill` stays at N-1.
- `en`=0: `hist`, `fill` and `cnt` hold, and `w`=0.
- `pat_load`=1:
  - `pat_r` <= `pat_in` and `fill` <= 0.
  - `w`=0 in that cycle, no count, and `j` is discarded.
  - `pat_load` has priority over matching.
- `cnt_clr`=1: `cnt` <= 0. This wins over a simultaneous match increment, so the counter reads 0 afterwards.
- Changing `overlap` takes effect at the next match edge. Partial history is kept.
- FSM view: `fill` is the state, with FILLING (0..N-2) and ARMED (N-1). ARMED->FILLING occurs only on a non-overlap match or a pattern load.

## Timing
- Reset (`rst`=0 at an edge):
  - `hist`=0, `fill`=0, `pat_r`=PATTERN, `cnt`=0.
  - `w` is forced 0 while `rst`=0.
  - Reset mid-stream discards the partial match. The first possible match is N sampled bits after the first edge with `rst`=1.
- `w` latency is zero cycles. It rises in the same cycle the last pattern bit is driven, so `j` must be stable before the rising edge. Glitches on `w` between edges are permitted.
- `match_cnt` updates one edge after a `w`=1 cycle.
- With `en` held at 1, the earliest match after reset or load is at the N-th sampled bit.

## Structure
- Shared package `seq_det_pkg` holds:
  - default constants `SEQ_N_DEF`=5, `SEQ_PATTERN_DEF`=5'b10010, `SEQ_CNT_W_DEF`=8;
  - a typedef for the fill/state encoding (FILLING/ARMED).
- Sub-module `sat_counter`, parameterised by width, with inputs `clk`, `rst`, `clr`, `inc` and output `q`. It clears with priority and saturates. It is instantiated once for `match_cnt`.
- The top level holds the history shift register, fill tracking, pattern register and the compare.

## Test plan
- Defaults, `overlap`=1, stream 1,0,0,1,0,0,1,0 (one bit per edge) -> `w`=1 during bits 5 and 8; `match_cnt`=2.
- Same stream with `overlap`=0 -> `w`=1 only at bit 5; `match_cnt`=1.
- Load `pat_in`=5'b11011 while the stream is mid-match, then send 1,1,0,1,1 -> no `w` in the load cycle; `w`=1 at the 5th bit after the load; the old pattern 10010 no longer matches.
- `rst`=0 for one edge after bits 1,0,0,1, then send 0 -> no match; `pat_r` returns to 10010; sending 1,0,0,1,0 afterwards matches on the 5th bit.
- `en` toggling: 1,0,(`en`=0 for 3 cycles with `j`=1),0,1,0 -> match on the last bit; `w`=0 throughout the disabled cycles.
- `CNT_W`=2, overlapping stream producing 5 matches -> `match_cnt` saturates at 3. `cnt_clr` asserted in the same cycle as a match -> `match_cnt`=0.

Source files
------------

// File: rtl/seq_det_pkg.sv
// Shared defaults and state encoding for the parametrised serial sequence detectors.
package seq_det_pkg;

    localparam int         SEQ_N_DEF       = 5;
    localparam logic [4:0] SEQ_PATTERN_DEF = 5'b10010;
    localparam int         SEQ_CNT_W_DEF   = 8;

    // FILLING: fewer than N-1 valid history bits; ARMED: a match is possible this cycle.
    typedef enum logic {
        FILLING = 1'b0,
        ARMED   = 1'b1
    } fill_state_e;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous active-low reset and priority clear.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] q
);

    always_ff @(posedge clk) begin
        if (!rst) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (inc && (q != {W{1'b1}})) begin
            q <= q + W'(1);
        end
    end

endmodule

// File: rtl/param_mealy_seq_detector.sv
// Mealy detector for a run-time loadable N-bit serial pattern with overlap control
// and a saturating match counter.
module param_mealy_seq_detector
    import seq_det_pkg::*;
#(
    parameter int           N       = SEQ_N_DEF,
    parameter logic [N-1:0] PATTERN = N'(SEQ_PATTERN_DEF),
    parameter int           CNT_W   = SEQ_CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             j,
    input  logic             en,
    input  logic             overlap,
    input  logic             pat_load,
    input  logic [N-1:0]     pat_in,
    input  logic             cnt_clr,
    output logic             w,
    output logic [CNT_W-1:0] match_cnt
);

    localparam int           FW   = (N > 2) ? $clog2(N) : 1;
    localparam logic [FW-1:0] FULL = FW'(N - 1);

    logic [N-2:0]  hist;
    logic [FW-1:0] fill;
    logic [N-1:0]  pat_r;
    logic [N-1:0]  window;
    fill_state_e   state;

    // Window is the last N-1 history bits plus the bit on j right now.
    assign window = {hist, j};
    assign state  = (fill == FULL) ? ARMED : FILLING;
    assign w      = rst & en & ~pat_load & (state == ARMED) & (window == pat_r);

    always_ff @(posedge clk) begin
        if (!rst) begin
            hist  <= '0;
            fill  <= '0;
            pat_r <= PATTERN;
        end else if (pat_load) begin
            pat_r <= pat_in;
            fill  <= '0;
        end else if (en) begin
            hist <= window[N-2:0];
            if (w && !overlap) begin
                fill <= '0;
            end else if (fill != FULL) begin
                fill <= fill + FW'(1);
            end
        end
    end

    sat_counter #(
        .W(CNT_W)
    ) u_cnt (
        .clk(clk),
        .rst(rst),
        .clr(cnt_clr),
        .inc(w),
        .q  (match_cnt)
    );

endmodule

// File: tb/tb_param_mealy_seq_detector.sv
// Randomised and directed bench for param_mealy_seq_detector against a queue-based model.
module tb_param_mealy_seq_detector;

    localparam int         N   = 5;
    localparam logic [4:0] PAT = 5'b10010;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       j = 1'b0;
    logic       en = 1'b0;
    logic       overlap = 1'b1;
    logic       pat_load = 1'b0;
    logic [4:0] pat_in = '0;
    logic       cnt_clr = 1'b0;
    logic       w, w2;
    logic [7:0] cnt8;
    logic [1:0] cnt2;

    int total = 0;
    int bad = 0;

    // Reference state: bits accepted since the current window began, pattern, raw match count.
    int         mq[$];
    logic [4:0] mp = PAT;
    int         mc = 0;

    param_mealy_seq_detector #(.N(5), .PATTERN(5'b10010), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .j(j), .en(en), .overlap(overlap), .pat_load(pat_load),
        .pat_in(pat_in), .cnt_clr(cnt_clr), .w(w), .match_cnt(cnt8)
    );

    param_mealy_seq_detector #(.N(5), .PATTERN(5'b10010), .CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .j(j), .en(en), .overlap(overlap), .pat_load(pat_load),
        .pat_in(pat_in), .cnt_clr(cnt_clr), .w(w2), .match_cnt(cnt2)
    );

    always #5 clk = ~clk;

    function automatic logic model_match(input logic jv);
        logic [4:0] v;
        if (mq.size() < N - 1) return 1'b0;
        v[0] = jv;
        for (int k = 1; k < N; k++) v[k] = mq[mq.size() - k][0];
        return v == mp;
    endfunction

    // Drive one cycle, sample outputs before the edge, then advance the model across the edge.
    task automatic cyc(input logic r, input logic jv, input logic ev, input logic ov,
                       input logic ld, input logic [4:0] pv, input logic cl,
                       output logic ow, output logic ow2, output logic ew,
                       output int oc8, output int ec8, output int oc2, output int ec2);
        @(negedge clk);
        rst = r; j = jv; en = ev; overlap = ov; pat_load = ld; pat_in = pv; cnt_clr = cl;
        #1;
        ew  = r && ev && !ld && model_match(jv);
        ow  = w;
        ow2 = w2;
        oc8 = int'(cnt8);
        oc2 = int'(cnt2);
        ec8 = (mc > 255) ? 255 : mc;
        ec2 = (mc > 3) ? 3 : mc;
        if (!r) begin
            mq.delete(); mp = PAT; mc = 0;
        end else begin
            if (ld) begin
                mp = pv; mq.delete();
            end else if (ev) begin
                mq.push_back(int'(jv));
                if (mq.size() > N - 1) void'(mq.pop_front());
                if (ew && !ov) mq.delete();
            end
            if (cl) mc = 0;
            else if (ew) mc++;
        end
    endtask

    logic ow, ow2, ew;
    int   oc8, ec8, oc2, ec2;

    task automatic test_reset();
        cyc(0, 1, 1, 1, 0, 5'd0, 0, ow, ow2, ew, oc8, ec8, oc2, ec2);
        total++; if (ow !== 1'b0) begin bad++; $display("FAIL reset_w got=%b want=0", ow); end
        cyc(0, 0, 1, 1, 0, 5'd0, 0, ow, ow2, ew, oc8, ec8, oc2, ec2);
        cyc(1, 0, 0, 1, 0, 5'd0, 0, ow, ow2, ew, oc8, ec8, oc2, ec2);
        total++; if (oc8 !== 0) begin bad++; $display("FAIL reset_cnt got=%0d want=0", oc8); end
        total++; if (ow !== 1'b0) begin bad++; $display("FAIL reset_w_idle got=%b want=0", ow); end
    endtask

    task automatic test_stream(input logic ov, input int want_cnt);
        int seq[8] = '{1, 0, 0, 1, 0, 0, 1, 0};
        int ex[8];
        ex = ov ? '{0, 0, 0, 0, 1, 0, 0, 1} : '{0, 0, 0, 0, 1, 0, 0, 0};
        cyc(0, 0, 1, ov, 0, 5'd0, 0, ow, ow2, ew, oc8, ec8, oc2, ec2);
        for (int i = 0; i < 8; i++) begin
            cyc(1, seq[i][0], 1, ov, 0, 5'd0, 0, ow, ow2, ew, oc8, ec8, oc2, ec2);
            total++;
            if (ow !== ex[i][0]) begin bad++; $display("FAIL stream_ov%0d bit%0d got=%b want=%b", ov, i + 1, ow, ex[i][0]); end
        end
        cyc(1, 0, 0, ov, 0, 5'd0, 0, ow, ow2, ew, oc8, ec8, oc2, ec2);
        total++;
        if (oc8 !== want_cnt) begin bad++; $display("FAIL stream_cnt_ov%0d got=%0d want=%0d", ov, oc8, want_cnt); end
    endtask

    task automatic test_load();
        int pre[4] = '{1, 0, 0, 1};
        int nb[5]  = '{1, 1, 0, 1, 1};
        int old[5] = '{1, 0, 0, 1, 0};
        cyc(0, 0, 1, 1, 0, 5'd0, 0, ow, ow2, ew, oc8, ec8, oc2, ec2);
        foreach (pre[i]) cyc(1, pre[i][0], 1, 1, 0, 5'd0, 0, ow, ow2, ew, oc8, ec8, oc2, ec2);
        cyc(1, 0, 1, 1, 1, 5'b11011, 0, ow, ow2, ew, oc8, ec8, oc2, ec2);
        total++; if (ow !== 1'b0) begin bad++; $display("FAIL load_cycle_w got=%b want=0", ow); end
        for (int i = 0; i < 5; i++) begin
            cyc(1, nb[i][0], 1, 1, 0, 5'd0, 0, ow, ow2, ew, oc8, ec8, oc2, ec2);
            total++;
            if (ow !== (i == 4)) begin bad++; $display("FAIL load_new bit%0d got=%b want=%b", i + 1, ow, i == 4); end
        end
        for (int i = 0; i < 5; i++) begin
            cyc(1, old[i][0], 1, 1, 0, 5'd0, 0, ow, ow2, ew, oc8, ec8, oc2, ec2);
            total++;
            if (ow !== 1'b0) begin bad++; $display("FAIL load_old bit%0d got=%b want=0", i + 1, ow); end
        end
        cyc(1, 0, 0, 1, 0, 5'd0, 0, ow, ow2, ew, oc8, ec8, oc2, ec2);
        total++; if (oc8 !== 1) begin bad++; $display("FAIL load_cnt got=%0d want=1", oc8); end
    endtask

    // Runs with pattern 11011 still loaded; only a return to 10010 can match below.
    task automatic test_rst_mid();
        int pre[4] = '{1, 0, 0, 1};
        int post[5] = '{1, 0, 0, 1, 0};
        foreach (pre[i]) cyc(1, pre[i][0], 1, 1, 0, 5'd0, 0, ow, ow2, ew, oc8, ec8, oc2, ec2);
        cyc(0, 0, 1, 1, 0, 5'd0, 0, ow, ow2, ew, oc8, ec8, oc2, ec2);
        total++; if (ow !== 1'b0) begin bad++; $display("FAIL rstmid_w got=%b want=0", ow); end
        cyc(1, 0, 1, 1, 0, 5'd0, 0, ow, ow2, ew, oc8, ec8, oc2, ec2);
        total++; if (ow !== 1'b0) begin bad++; $display("FAIL rstmid_after got=%b want=0", ow); end
        for (int i = 0; i < 5; i++) begin
            cyc(1, post[i][0], 1, 1, 0, 5'd0, 0, ow, ow2, ew, oc8, ec8, oc2, ec2);
            total++;
            if (ow !== (i == 4)) begin bad++; $display("FAIL rstmid_post bit%0d got=%b want=%b", i + 1, ow, i == 4); end
        end
    endtask

    task automatic test_en();
        cyc(0, 0, 1, 1, 0, 5'd0, 0, ow, ow2, ew, oc8, ec8, oc2, ec2);
        cyc(1, 1, 1, 1, 0, 5'd0, 0, ow, ow2, ew, oc8, ec8, oc2, ec2);
        cyc(1, 0, 1, 1, 0, 5'd0, 0, ow, ow2, ew, oc8, ec8, oc2, ec2);
        for (int i = 0; i < 3; i++) begin
            cyc(1, 1, 0, 1, 0, 5'd0, 0, ow, ow2, ew, oc8, ec8, oc2, ec2);
            total++; if (ow !== 1'b0) begin bad++; $display("FAIL en_off cyc%0d got=%b want=0", i, ow); end
        end
        cyc(1, 0, 1, 1, 0, 5'd0, 0, ow, ow2, ew, oc8, ec8, oc2, ec2);
        total++; if (ow !== 1'b0) begin bad++; $display("FAIL en_bit3 got=%b want=0", ow); end
        cyc(1, 1, 1, 1, 0, 5'd0, 0, ow, ow2, ew, oc8, ec8, oc2, ec2);
        total++; if (ow !== 1'b0) begin bad++; $display("FAIL en_bit4 got=%b want=0", ow); end
        cyc(1, 0, 1, 1, 0, 5'd0, 0, ow, ow2, ew, oc8, ec8, oc2, ec2);
        total++; if (ow !== 1'b1) begin bad++; $display("FAIL en_match got=%b want=1", ow); end
    endtask

    task automatic test_saturate();
        cyc(0, 0, 1, 1, 0, 5'd0, 0, ow, ow2, ew, oc8, ec8, oc2, ec2);
        for (int i = 0; i < 17; i++) begin
            cyc(1, (i % 3) == 0, 1, 1, 0, 5'd0, 0, ow, ow2, ew, oc8, ec8, oc2, ec2);
            total++;
            if (ow2 !== ((i % 3) == 1 && i >= 4)) begin
                bad++; $display("FAIL sat_w bit%0d got=%b want=%b", i + 1, ow2, (i % 3) == 1 && i >= 4);
            end
        end
        cyc(1, 0, 0, 1, 0, 5'd0, 0, ow, ow2, ew, oc8, ec8, oc2, ec2);
        total++; if (oc2 !== 3) begin bad++; $display("FAIL sat_cnt2 got=%0d want=3", oc2); end
        total++; if (oc8 !== 5) begin bad++; $display("FAIL sat_cnt8 got=%0d want=5", oc8); end
        for (int i = 17; i < 20; i++) begin
            cyc(1, (i % 3) == 0, 1, 1, 0, 5'd0, i == 19, ow, ow2, ew, oc8, ec8, oc2, ec2);
        end
        total++; if (ow !== 1'b1) begin bad++; $display("FAIL clr_match_w got=%b want=1", ow); end
        cyc(1, 0, 0, 1, 0, 5'd0, 0, ow, ow2, ew, oc8, ec8, oc2, ec2);
        total++; if (oc8 !== 0) begin bad++; $display("FAIL clr_cnt8 got=%0d want=0", oc8); end
        total++; if (oc2 !== 0) begin bad++; $display("FAIL clr_cnt2 got=%0d want=0", oc2); end
    endtask

    task automatic test_random();
        logic ov;
        logic [4:0] pv;
        ov = 1'b1;
        cyc(0, 0, 1, ov, 0, 5'd0, 0, ow, ow2, ew, oc8, ec8, oc2, ec2);
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 19) == 0) ov = ~ov;
            pv = ($urandom_range(0, 1) == 0) ? 5'b10101 : 5'($urandom);
            cyc($urandom_range(0, 149) != 0, 1'($urandom), $urandom_range(0, 7) != 0, ov,
                $urandom_range(0, 39) == 0, pv, $urandom_range(0, 59) == 0,
                ow, ow2, ew, oc8, ec8, oc2, ec2);
            total++; if (ow !== ew) begin bad++; $display("FAIL rand_w i=%0d got=%b want=%b", i, ow, ew); end
            total++; if (ow2 !== ew) begin bad++; $display("FAIL rand_w2 i=%0d got=%b want=%b", i, ow2, ew); end
            total++; if (oc8 !== ec8) begin bad++; $display("FAIL rand_cnt8 i=%0d got=%0d want=%0d", i, oc8, ec8); end
            total++; if (oc2 !== ec2) begin bad++; $display("FAIL rand_cnt2 i=%0d got=%0d want=%0d", i, oc2, ec2); end
        end
    endtask

    initial begin
        test_reset();
        test_stream(1'b1, 2);
        test_stream(1'b0, 1);
        test_load();
        test_rst_mid();
        test_en();
        test_saturate();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
